apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Parametrised APB4 master that turns a simple valid/ready request/response command port into compliant APB SETUP/ACCESS transfers. Extends the existing 32-bit APB signal set with configurable address/data width, byte strobes (pstrb), protection (pprot), and an ACCESS-phase timeout that aborts hung slaves. It sits between a bus-initiating block (test sequencer, DMA, CPU shim) and the APB slaves of the peripheral subsystem.

## Interface
- ADDR_W, 32, width of paddr/req_addr
- DATA_W, 32, width of data buses; multiple of 8, max 64
- TIMEOUT, 16, max ACCESS cycles waiting for pready before abort; 0 disables timeout
- pclk  in  1  APB clock; all logic on rising edge
- presetn  in  1  asynchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready
- req_addr  in  ADDR_W  target address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts
- rsp_err  out  1  pslverr sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr, pwdata, pstrb, pprot, pwrite, psel, penable  out  ADDR_W, DATA_W, DATA_W/8, 3, 1, 1, 1  APB master outputs
- prdata, pready, pslverr  in  DATA_W, 1, 1  APB slave returns

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready = 1. On accept, register addr/write/wdata/strb/prot into APB output flops; go SETUP.
- SETUP: psel=1, penable=0; unconditionally go ACCESS.
- ACCESS: psel=1, penable=1. On pready: capture prdata (reads only), rsp_err=pslverr, rsp_timeout=0; go RESP.
- Timeout: counter clears on entering ACCESS, increments each ACCESS cycle without pready. If TIMEOUT≠0 and pready is still low in the TIMEOUT-th ACCESS cycle, abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0; go RESP. pready in that same cycle wins over timeout.
- RESP: psel=0, penable=0, rsp_valid=1; response fields stable until rsp_ready; then IDLE.
- pstrb driven 0 for reads (APB4 rule), req_strb for writes.
- paddr/pwrite/pwdata/pstrb/pprot stable from SETUP through ACCESS end; hold last value after transfer (no toggling in IDLE).
- One outstanding transfer; req_ready = 0 outside IDLE.

## Timing
- Reset (async assert, sync release): state IDLE; psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; req_ready = 1.
- Accept at edge N → SETUP cycle N+1 → ACCESS from N+2. Zero-wait slave (pready=1 at N+2) → rsp_valid from N+3. Each slave wait state adds 1 cycle.
- rsp_ready=1 in first RESP cycle → IDLE next cycle; minimum 4 cycles per transfer, accept-to-accept.
- Timeout with TIMEOUT=T: ACCESS lasts exactly T cycles, rsp_valid in cycle after.
- Reset mid-transfer: psel/penable drop immediately; in-flight request and pending response discarded.
- Response stall (rsp_ready=0) never affects APB outputs (already idle).

## Structure
- apb_pkg: state enum typedef, APB_PROT_* constants (privileged/non-secure/instruction bits), response struct (rdata, err, timeout) parametrised via localparam defaults.
- One sub-module: apb_tmo_cnt (clear/enable/expire counter, width $clog2(TIMEOUT+1), tied off when TIMEOUT=0).
- APB outputs map 1:1 onto the existing apb_if; extended signals pstrb/pprot added to apb_if as a new generation.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, strb 0xF, zero-wait slave → SETUP 1 cycle, ACCESS 1 cycle, pstrb=0xF, rsp_err=0, rsp_valid at accept+3.
- Read 0x0000_0020, slave inserts 3 wait states returning 0x1234_5678 → ACCESS 4 cycles, pstrb=0, rsp_rdata=0x1234_5678.
- Write with pslverr=1 on completion → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT=16, slave never asserts pready → ACCESS exactly 16 cycles, psel drops, rsp_err=1, rsp_timeout=1; TIMEOUT=0 → bus waits indefinitely (checked 1000 cycles).
- Hold rsp_ready=0 for 10 cycles then 1 while req_valid held high → req_ready stays 0 until after handshake, response fields stable, next request accepted following cycle.
- Assert presetn low during ACCESS → psel/penable/rsp_valid 0 same cycle, state IDLE, req_ready=1 after release.

Source files
------------

// File: rtl/apb_master_ctrl_pkg.sv
// apb_master_ctrl_pkg: FSM states, APB protection bits and response record shared by the APB master controller
package apb_master_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  localparam logic [2:0] APB_PROT_PRIV  = 3'b001;
  localparam logic [2:0] APB_PROT_NSEC  = 3'b010;
  localparam logic [2:0] APB_PROT_INSTR = 3'b100;
  localparam int RSP_DATA_MAX = 64;
  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    logic                    err;
    logic                    timeout;
  } rsp_t;
  function automatic int tmo_w(int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: command/response port and APB4 bus (with pstrb/pprot) of the APB master controller
interface apb_master_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_write;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_strb;
  logic [2:0]          req_prot;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                rsp_timeout;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [2:0]          pprot;
  logic                pwrite;
  logic                psel;
  logic                penable;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, rsp_ready,
           prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwdata, pstrb, pprot, pwrite, psel, penable
  );
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, rsp_ready,
           prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwdata, pstrb, pprot, pwrite, psel, penable
  );
endinterface

// File: rtl/apb_master_ctrl_tmo_cnt.sv
// apb_master_ctrl_tmo_cnt: ACCESS-phase wait counter; expire_o flags the last allowed cycle without pready
module apb_master_ctrl_tmo_cnt
  import apb_master_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = tmo_w(TIMEOUT);
  if (TIMEOUT == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = clk_i ^ rst_ni ^ clr_i ^ en_i;
    assign expire_o   = 1'b0;
  end else begin : g_on
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    // counter holds (cycles already waited); the TIMEOUT-th idle cycle sees TIMEOUT-1
    assign expire_o = en_i && (cnt_q == W'(TIMEOUT - 1));
  end
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: valid/ready command port to APB4 SETUP/ACCESS transfers with an ACCESS-phase timeout
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_master_ctrl_if.master  bus
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                pwrite_q, pwrite_d;
  rsp_t                rsp_q, rsp_d;
  logic                accept, done, expire;

  apb_master_ctrl_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i    (pclk),
    .rst_ni   (presetn),
    .clr_i    (state_q == SETUP),
    .en_i     (state_q == ACCESS && !bus.pready),
    .expire_o (expire)
  );

  assign accept = bus.req_valid && bus.req_ready;
  assign done   = (state_q == ACCESS) && (bus.pready || expire);

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    pwrite_d = pwrite_q;
    rsp_d    = rsp_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d  = SETUP;
        paddr_d  = bus.req_addr;
        pwdata_d = bus.req_wdata;
        pstrb_d  = bus.req_write ? bus.req_strb : '0;
        pprot_d  = bus.req_prot;
        pwrite_d = bus.req_write;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (done) begin
        state_d       = RESP;
        rsp_d.rdata   = (bus.pready && !pwrite_q) ? RSP_DATA_MAX'(bus.prdata) : '0;
        rsp_d.err     = bus.pready ? bus.pslverr : 1'b1;
        rsp_d.timeout = !bus.pready;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      pwrite_q <= pwrite_d;
      rsp_q    <= rsp_d;
    end

  // handshake outputs decode the state directly so an async reset drops them at once
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable     = (state_q == ACCESS);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;

  ap_pen_sel: assert property (@(posedge pclk) disable iff (!presetn) bus.penable |-> bus.psel);
  ap_stable:  assert property (@(posedge pclk) disable iff (!presetn)
                               state_q == ACCESS |-> $stable(paddr_q) && $stable(pwdata_q) && $stable(pwrite_q));
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: randomized transfers against a transaction-level timing model of the APB master
module tb_apb_master_ctrl;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut  (.pclk(clk), .presetn(rst_n), .bus(bus));
  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (.pclk(clk), .presetn(rst_n), .bus(bus0));

  int checks = 0;
  int failures = 0;
  int cyc = -1;
  bit mon_on = 1'b0;
  logic [31:0] c_addr, c_wdata, c_rdata, p_addr, p_wdata;
  logic [3:0]  c_strb, p_strb;
  logic [2:0]  c_prot, p_prot;
  logic        c_write, c_err, c_tmo, p_write;
  int          c_len;
  int          m_acc, m_rsp;
  logic [31:0] m_rdata;
  logic        m_err, m_tmo;

  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endfunction

  // expected bus behaviour from transfer-level durations: SETUP 1 cycle, ACCESS c_len cycles, then RESP
  always @(negedge clk) if (mon_on) begin
    if (cyc < 0) begin
      chk("idle_req_ready", 64'(bus.req_ready), 64'(1));
      chk("idle_psel", 64'(bus.psel), 64'(0));
      chk("idle_penable", 64'(bus.penable), 64'(0));
      chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("idle_paddr", 64'(bus.paddr), 64'(p_addr));
      chk("idle_pwdata", 64'(bus.pwdata), 64'(p_wdata));
      chk("idle_pstrb", 64'(bus.pstrb), 64'(p_strb));
      chk("idle_pprot", 64'(bus.pprot), 64'(p_prot));
      chk("idle_pwrite", 64'(bus.pwrite), 64'(p_write));
    end else begin
      if (cyc == 0) begin m_acc = 0; m_rsp = -1; end
      if (bus.psel && bus.penable) m_acc++;
      if (bus.rsp_valid && m_rsp < 0) begin
        m_rsp = cyc; m_rdata = bus.rsp_rdata; m_err = bus.rsp_err; m_tmo = bus.rsp_timeout;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(cyc == 0));
      chk("psel", 64'(bus.psel), 64'(cyc >= 1 && cyc <= 1 + c_len));
      chk("penable", 64'(bus.penable), 64'(cyc >= 2 && cyc <= 1 + c_len));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(cyc >= 2 + c_len));
      chk("paddr", 64'(bus.paddr), 64'(cyc >= 1 ? c_addr : p_addr));
      chk("pwdata", 64'(bus.pwdata), 64'(cyc >= 1 ? c_wdata : p_wdata));
      chk("pstrb", 64'(bus.pstrb), 64'(cyc >= 1 ? (c_write ? c_strb : 4'h0) : p_strb));
      chk("pprot", 64'(bus.pprot), 64'(cyc >= 1 ? c_prot : p_prot));
      chk("pwrite", 64'(bus.pwrite), 64'(cyc >= 1 ? c_write : p_write));
      if (cyc >= 2 + c_len) begin
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'((c_tmo || c_write) ? 32'h0 : c_rdata));
        chk("rsp_err", 64'(bus.rsp_err), 64'(c_tmo || c_err));
        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(c_tmo));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cyc = -1;
      bus.req_valid = 1'b0;
      bus.pready    = 1'($urandom);
      bus.pslverr   = 1'($urandom);
      bus.prdata    = $urandom;
      bus.rsp_ready = 1'($urandom);
    end
  endtask

  // waits = slave wait states before pready; d = extra RESP cycles before rsp_ready; hold keeps req_valid high
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input logic [31:0] rdata,
                         input logic err, input int waits, input int d, input bit hold);
    int r;
    bit in_acc, fin;
    c_addr = addr; c_write = wr; c_wdata = wdata; c_strb = strb; c_prot = prot;
    c_rdata = rdata; c_err = err;
    c_tmo = (T != 0) && (waits >= T);
    c_len = c_tmo ? T : waits + 1;
    r = 2 + c_len + d;
    for (int c = 0; c <= r; c++) begin
      @(posedge clk); #1;
      cyc = c;
      in_acc = (c >= 2) && (c <= 1 + c_len);
      fin = in_acc && !c_tmo && (c == 1 + c_len);
      bus.req_valid = (c == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom));
      bus.req_addr  = (c == 0) ? addr : $urandom;
      bus.req_write = (c == 0) ? wr : 1'($urandom);
      bus.req_wdata = (c == 0) ? wdata : $urandom;
      bus.req_strb  = (c == 0) ? strb : 4'($urandom);
      bus.req_prot  = (c == 0) ? prot : 3'($urandom);
      bus.pready    = in_acc ? fin : 1'($urandom);
      bus.prdata    = fin ? rdata : $urandom;
      bus.pslverr   = fin ? err : 1'($urandom);
      bus.rsp_ready = (c >= 2 + c_len) ? (c == r) : 1'($urandom);
    end
    @(negedge clk); #1;
    p_addr = addr; p_wdata = wdata; p_write = wr; p_prot = prot; p_strb = wr ? strb : 4'h0;
  endtask

  initial begin
    logic [31:0] ra, rw, rd;
    logic [3:0]  rs;
    logic [2:0]  rp;
    logic        rwr, re;
    int          rwait, ok;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_write = 0; bus.req_wdata = 0; bus.req_strb = 0;
    bus.req_prot = 0; bus.rsp_ready = 0; bus.prdata = 0; bus.pready = 0; bus.pslverr = 0;
    bus0.req_valid = 0; bus0.req_addr = 0; bus0.req_write = 0; bus0.req_wdata = 0; bus0.req_strb = 0;
    bus0.req_prot = 0; bus0.rsp_ready = 0; bus0.prdata = 0; bus0.pready = 0; bus0.pslverr = 0;
    p_addr = 0; p_wdata = 0; p_strb = 0; p_prot = 0; p_write = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_psel", 64'(bus.psel), 64'(0));
    chk("rst_penable", 64'(bus.penable), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_paddr", 64'(bus.paddr), 64'(0));
    chk("rst_pwdata", 64'(bus.pwdata), 64'(0));
    chk("rst_pstrb", 64'(bus.pstrb), 64'(0));
    chk("rst_rsp_fields", 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.pwrite, bus.pprot}), 64'(0));
    rst_n = 1'b1;
    cyc = -1; mon_on = 1'b1;
    idle(2);

    run_txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, 1'b0, 0, 0, 1'b0);
    chk("t1_access_cycles", 64'(m_acc), 64'(1));
    chk("t1_rsp_latency", 64'(m_rsp), 64'(3));
    chk("t1_rsp_err", 64'(m_err), 64'(0));
    idle(1);
    run_txn(32'h0000_0020, 1'b0, 32'h0, 4'hA, 3'b010, 32'h1234_5678, 1'b0, 3, 0, 1'b0);
    chk("t2_access_cycles", 64'(m_acc), 64'(4));
    chk("t2_rsp_latency", 64'(m_rsp), 64'(6));
    chk("t2_rdata", 64'(m_rdata), 64'(32'h1234_5678));
    run_txn(32'h0000_0030, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b001, 32'h5555_AAAA, 1'b1, 1, 2, 1'b0);
    chk("t3_err", 64'({m_err, m_tmo}), 64'(2'b10));
    chk("t3_rdata", 64'(m_rdata), 64'(0));
    run_txn(32'h0000_0040, 1'b0, 32'h0, 4'hF, 3'b111, 32'h7777_7777, 1'b0, 100, 0, 1'b0);
    chk("t4_tmo_access_cycles", 64'(m_acc), 64'(16));
    chk("t4_tmo_latency", 64'(m_rsp), 64'(18));
    chk("t4_tmo_flags", 64'({m_err, m_tmo, m_rdata}), 64'({2'b11, 32'h0}));
    run_txn(32'h0000_0050, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0BAD_F00D, 1'b0, 15, 0, 1'b0);
    chk("t5_last_cycle_pready", 64'({m_acc, m_tmo}), 64'({32'd16, 1'b0}));
    chk("t5_rdata", 64'(m_rdata), 64'(32'h0BAD_F00D));
    run_txn(32'h0000_0060, 1'b1, 32'h1111_2222, 4'h5, 3'b000, 32'h0, 1'b0, 0, 10, 1'b1);
    chk("t6_stall_latency", 64'(m_rsp), 64'(3));
    run_txn(32'h0000_0064, 1'b0, 32'h0, 4'h0, 3'b000, 32'h9999_0000, 1'b0, 0, 0, 1'b0);
    chk("t6_back_to_back_rdata", 64'(m_rdata), 64'(32'h9999_0000));

    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rw = $urandom; rd = $urandom; rs = 4'($urandom); rp = 3'($urandom);
      rwr = 1'($urandom); re = ($urandom_range(0, 3) == 0);
      rwait = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 22)) : int'($urandom_range(0, 4));
      run_txn(ra, rwr, rw, rs, rp, rd, re, rwait, int'($urandom_range(0, 3)), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    mon_on = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_addr = 32'hA5A5_0000; bus.req_write = 1'b0; bus.pready = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_pre_access", 64'({bus.psel, bus.penable}), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", 64'({bus.psel, bus.penable, bus.rsp_valid}), 64'(0));
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_mid_paddr", 64'(bus.paddr), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_release_idle", 64'({bus.req_ready, bus.psel, bus.rsp_valid}), 64'(3'b100));
    p_addr = 0; p_wdata = 0; p_strb = 0; p_prot = 0; p_write = 0;
    cyc = -1; mon_on = 1'b1;
    idle(1);
    run_txn(32'h0000_0070, 1'b1, 32'h0F0F_0F0F, 4'hC, 3'b100, 32'h0, 1'b0, 2, 1, 1'b0);
    chk("post_rst_access_cycles", 64'(m_acc), 64'(3));
    mon_on = 1'b0;

    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0000_0080; bus0.req_write = 1'b0;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    @(posedge clk); #1;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus0.psel && bus0.penable && !bus0.rsp_valid && !bus0.req_ready) ok++;
    end
    chk("tmo0_waits_1000", 64'(ok), 64'(1000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
